multiword_add_seq: RTL

Sequential multi-word adder. Adds two WIDTH*WORDS-bit operands over WORDS cycles by passing one WIDTH-bit slice per cycle through a combinational WIDTH-bit adder slice. The carry-out of each slice is registered and fed back as the carry-in of the next slice. Sits between an operand source (valid/ready) and a result sink (valid/ready), so wide additions reuse one narrow adder.

---
 rtl/add_pkg.sv | 13 +
 rtl/adder_slice.sv | 18 +
 rtl/multiword_add_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared types and default sizing for the sequential multi-word adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADD_WIDTH = 4;
    localparam int ADD_WORDS = 4;

endpackage

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit adder with carry in and carry out.
module adder_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum    = w_full[WIDTH-1:0];
    assign cout   = w_full[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per cycle, LSB first,
// rippling the registered carry between cycles through a single adder slice.
module multiword_add_seq
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int WORDS = ADD_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_carry;
    logic                          r_cout;
    logic [WORDS-1:0][WIDTH-1:0]   r_a;
    logic [WORDS-1:0][WIDTH-1:0]   r_b;
    logic [WORDS-1:0][WIDTH-1:0]   r_sum;

    logic [WIDTH-1:0]              w_slice_sum;
    logic                          w_slice_cout;

    adder_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Handshake flags decode state only, so no input reaches them combinationally.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_slice_sum;
                    r_carry      <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_slice_cout;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result stays put until the sink takes it; no new accept here.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
